muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and HI/LO register width; legal values are 4..64.
REQ-002 SHALL have clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have start, input, 1 bit: the issue slot holds a HI/LO-class instruction this cycle.
REQ-005 SHALL have funct, input, 6 bits: MIPS R-type function field.
REQ-006 SHALL have a, input, WIDTH bits: rs operand.
REQ-007 SHALL have b, input, WIDTH bits: rt operand.
REQ-008 SHALL have stall, output, 1 bit: the issuing pipeline holds the instruction.
REQ-009 SHALL have busy, output, 1 bit: a mult/div iteration is in flight.
REQ-010 SHALL have done, output, 1 bit: one-cycle pulse; new HI/LO values are visible.
REQ-011 SHALL have hi, output, WIDTH bits: HI register.
REQ-012 SHALL have lo, output, WIDTH bits: LO register.
REQ-013 SHALL have rdata, output, WIDTH bits: mfhi/mflo read data.

Function
REQ-014 SHALL decode these funct codes when start=1: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
REQ-015 SHALL treat start=1 with any other funct as a no-op, with no state change and stall=0.
REQ-016 SHALL implement the FSM states IDLE, MUL, DIV and FIX: IDLE->MUL on accepted mult/multu; IDLE->DIV on accepted div/divu; MUL or DIV->FIX after WIDTH iterations; FIX->IDLE.
REQ-017 SHALL accept a mult/div at a clock edge E0 only when start=1 and busy=0, capturing a, b and signedness at E0; later changes to a or b SHALL NOT affect the result.
REQ-018 SHALL hold busy=1 for exactly WIDTH+1 cycles after E0 (WIDTH iteration cycles plus one FIX cycle).
REQ-019 SHALL write hi/lo at the edge ending FIX, then drive done=1 for exactly one cycle with busy=0; for WIDTH=32, done is high in cycle 34 after E0.
REQ-020 SHALL compute mult/multu as shift-add, one bit per cycle, on magnitudes, applying sign correction in FIX; hi:lo is the full 2*WIDTH-bit signed or unsigned product.
REQ-021 SHALL compute div/divu as restoring division, one quotient bit per cycle; lo=quotient and hi=remainder.
REQ-022 SHALL truncate signed quotients toward zero and give the signed remainder the sign of the dividend.
REQ-023 SHALL handle divide by zero (signed or unsigned) as: hi=a, lo=all ones, same latency.
REQ-024 SHALL handle signed overflow (a=most negative, b=-1) as: lo=most negative, hi=0.
REQ-025 SHALL make stall=start & busy & (funct is any code in REQ-014), combinationally.
REQ-026 SHALL ignore any stalled instruction; the same instruction is re-presented and is accepted once busy=0.
REQ-027 SHALL write a to hi (mthi) or to lo (mtlo) at the next edge when busy=0, with busy and done unaffected.
REQ-028 SHALL drive rdata combinationally: hi when funct=mfhi, lo when funct=mflo, otherwise 0; rdata is valid only when stall=0.
REQ-029 SHALL let mfhi/mflo in the done cycle read the new result.
REQ-030 SHALL NOT raise exceptions, and SHALL leave hi/lo unchanged until the FIX edge.

Reset
REQ-031 SHALL, while rst=1 and independent of clk, force state=IDLE, busy=0, done=0, hi=0, lo=0 and clear the iteration counter and operand registers.
REQ-032 SHALL discard any operation in flight when rst asserts mid-operation; no done pulse is produced afterwards.
REQ-033 SHALL accept a new instruction at the first rising edge after rst deasserts.

Verification (WIDTH=32)
REQ-034 SHALL cover signed multiply: mult a=0xFFFFFFFD, b=0x00000007 -> done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB; multu on the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
REQ-035 SHALL cover division: divu 100/7 -> lo=0x0000000E, hi=0x00000002; div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 SHALL cover division corner cases: div 5/0 -> hi=0x00000005, lo=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 SHALL cover issue while busy: mflo, then a second mult, issued during busy -> stall=1 every busy cycle, second mult not started, mflo returns the new lo in the done cycle.
REQ-038 SHALL cover mid-operation reset: rst pulsed in cycle 10 of a div -> busy, done, hi and lo at 0 before the next edge, no done afterwards; then mthi a=0x1234 -> hi=0x00001234 after one edge.
REQ-039 SHALL cover the undefined funct: start=1, funct=100000 -> stall=0, hi/lo unchanged, busy=0.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Issue-slot bundle between the pipeline and the HI/LO multiply/divide unit.
// The pipeline drives the master side; the unit implements the slave side.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rdata;

    modport master (
        output start, funct, a, b,
        input  stall, busy, done, hi, lo, rdata
    );

    modport slave (
        input  start, funct, a, b,
        output stall, busy, done, hi, lo, rdata
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO unit: shift-add multiply and restoring divide, one bit per cycle,
// with sign fix-up in a final FIX cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             divz_q, divz_d;
    logic             mul_q, mul_d;
    logic             done_q, done_d;

    logic             is_mul, is_div, is_hilo, is_sgn, busy, accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_comb begin
        is_mul  = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
        is_div  = (bus.funct == F_DIV) || (bus.funct == F_DIVU);
        is_hilo = is_mul || is_div || (bus.funct == F_MFHI) || (bus.funct == F_MTHI) ||
                  (bus.funct == F_MFLO) || (bus.funct == F_MTLO);
        is_sgn  = ~bus.funct[0];
        busy    = (state_q != StIdle);
        accept  = bus.start && !busy;
        a_neg   = is_sgn && bus.a[WIDTH-1];
        b_neg   = is_sgn && bus.b[WIDTH-1];
        a_mag   = a_neg ? -bus.a : bus.a;
        b_mag   = b_neg ? -bus.b : bus.b;
    end

    // Iteration datapath: acc is the running high half / partial remainder, sh the low half /
    // dividend-to-quotient shift register.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, sh_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_q};
        prod      = {acc_q, sh_q};
        prod_fix  = neg_lo_q ? -prod : prod;
        quo_fix   = neg_lo_q ? -sh_q : sh_q;
        rem_fix   = neg_hi_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        opb_d    = opb_q;
        opa_d    = opa_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        divz_d   = divz_q;
        mul_d    = mul_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept && (is_mul || is_div)) begin
                    state_d  = is_mul ? StMul : StDiv;
                    cnt_d    = '0;
                    acc_d    = '0;
                    sh_d     = a_mag;
                    opb_d    = b_mag;
                    opa_d    = bus.a;
                    mul_d    = is_mul;
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    divz_d   = (bus.b == '0);
                end else if (accept && bus.funct == F_MTHI) begin
                    hi_d = bus.a;
                end else if (accept && bus.funct == F_MTLO) begin
                    lo_d = bus.a;
                end
            end
            StMul: begin
                acc_d = mul_sum[WIDTH:1];
                sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = StFix;
            end
            StDiv: begin
                if (!div_trial[WIDTH]) begin
                    acc_d = div_trial[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = StFix;
            end
            StFix: begin
                if (mul_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (divz_q) begin
                    hi_d = opa_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opb_q    <= '0;
            opa_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            divz_q   <= 1'b0;
            mul_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            opb_q    <= opb_d;
            opa_q    <= opa_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            divz_q   <= divz_d;
            mul_q    <= mul_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.stall = bus.start && busy && is_hilo;
    assign bus.rdata = (bus.funct == F_MFHI) ? hi_q :
                       (bus.funct == F_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): an arithmetic reference model compared every cycle,
// plus directed operations with hand-computed results.
module tb_muldiv_unit;
    localparam int unsigned W = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    muldiv_unit_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_muldiv(input logic [5:0] f);
        return f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU;
    endfunction

    function automatic bit is_valid(input logic [5:0] f);
        return is_muldiv(f) || f == F_MFHI || f == F_MTHI || f == F_MFLO || f == F_MTLO;
    endfunction

    // Reference results from plain integer arithmetic.
    task automatic compute(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] rh, output logic [31:0] rl);
        longint      sx, sy, sp;
        logic [63:0] up;
        int          ix, iy;
        rh = '0;
        rl = '0;
        if (f == F_MULT) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            sp = sx * sy;
            {rh, rl} = sp;
        end else if (f == F_MULTU) begin
            up = {32'h0, x} * {32'h0, y};
            {rh, rl} = up;
        end else if (y == 32'h0) begin
            rh = x;
            rl = 32'hFFFF_FFFF;
        end else if (f == F_DIV) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                rl = 32'h8000_0000;
                rh = 32'h0;
            end else begin
                ix = x;
                iy = y;
                rl = ix / iy;
                rh = ix % iy;
            end
        end else begin
            rl = x / y;
            rh = x % y;
        end
    endtask

    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_left = 0;
    bit          m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                    m_done = 1'b1;
                end
            end else if (bus.start) begin
                if (is_muldiv(bus.funct)) begin
                    compute(bus.funct, bus.a, bus.b, p_hi, p_lo);
                    m_left = W + 1;
                end else if (bus.funct == F_MTHI) begin
                    m_hi = bus.a;
                end else if (bus.funct == F_MTLO) begin
                    m_lo = bus.a;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_stall;
        if (!rst) begin
            exp_stall = bus.start && (m_left > 0) && is_valid(bus.funct);
            check("m_busy", 64'(bus.busy), 64'(m_left > 0));
            check("m_done", 64'(bus.done), 64'(m_done));
            check("m_stall", 64'(bus.stall), 64'(exp_stall));
            check("m_hi", 64'(bus.hi), 64'(m_hi));
            check("m_lo", 64'(bus.lo), 64'(m_lo));
            if (!exp_stall)
                check("m_rdata", 64'(bus.rdata),
                      bus.funct == F_MFHI ? 64'(m_hi) : bus.funct == F_MFLO ? 64'(m_lo) : 64'h0);
        end
    end

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        int cyc;
        bit got;
        @(posedge clk); #2;
        bus.start = 1'b1; bus.funct = f; bus.a = x; bus.b = y;
        @(posedge clk); #2;
        bus.start = 1'b0; bus.funct = 6'b000000; bus.a = $urandom; bus.b = $urandom;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done) got = 1'b1;
        end
        check({name, "_lat"}, 64'(cyc), 64'd34);
        check({name, "_busy"}, 64'(bus.busy), 64'd0);
        check({name, "_hi"}, 64'(bus.hi), 64'(eh));
        check({name, "_lo"}, 64'(bus.lo), 64'(el));
    endtask

    initial begin
        int c, stalls, dones;
        bus.start = 1'b0; bus.funct = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        #1 rst = 1'b0;

        run_op("mult", F_MULT, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu", F_MULTU, 32'hFFFF_FFFD, 32'h7, 32'h6, 32'hFFFF_FFEB);
        run_op("divu", F_DIVU, 32'd100, 32'd7, 32'h2, 32'hE);
        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_zero", F_DIV, 32'd5, 32'd0, 32'h5, 32'hFFFF_FFFF);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("divu_zero", F_DIVU, 32'd5, 32'd0, 32'h5, 32'hFFFF_FFFF);
        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
        run_op("div_negb", F_DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
        run_op("divu_big", F_DIVU, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);

        // Issue while busy: a second mult, then mflo, both held until the done cycle.
        @(posedge clk); #2;
        bus.start = 1'b1; bus.funct = F_MULT; bus.a = 32'h10; bus.b = 32'h20;
        @(posedge clk); #2;
        bus.a = 32'd9; bus.b = 32'd9;
        stalls = 0;
        c = 1;
        while (c < 60) begin
            #1;
            if (!bus.stall) break;
            stalls++;
            @(posedge clk); #2;
            c++;
            if (c == 11) bus.funct = F_MFLO;
        end
        check("ib_stalls", 64'(stalls), 64'd33);
        check("ib_cycle", 64'(c), 64'd34);
        check("ib_done", 64'(bus.done), 64'd1);
        check("ib_rdata", 64'(bus.rdata), 64'h200);
        @(posedge clk); #2;
        bus.start = 1'b0;
        #1 check("ib_not_started", 64'(bus.busy), 64'd0);

        // Undefined funct is a no-op.
        @(posedge clk); #2;
        bus.start = 1'b1; bus.funct = 6'b100000; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1;
        #1 check("undef_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #2;
        bus.start = 1'b0;
        #1;
        check("undef_busy", 64'(bus.busy), 64'd0);
        check("undef_hi", 64'(bus.hi), 64'h0);
        check("undef_lo", 64'(bus.lo), 64'h200);

        // mtlo / mthi / mfhi.
        @(posedge clk); #2;
        bus.start = 1'b1; bus.funct = F_MTLO; bus.a = 32'hABCD;
        @(posedge clk); #2;
        bus.funct = F_MTHI; bus.a = 32'h55;
        #1 check("mtlo_lo", 64'(bus.lo), 64'hABCD);
        @(posedge clk); #2;
        bus.funct = F_MFHI;
        #1 check("mfhi_rdata", 64'(bus.rdata), 64'h55);
        @(posedge clk); #2;
        bus.start = 1'b0;

        // Reset in cycle 10 of a divide.
        @(posedge clk); #2;
        bus.start = 1'b1; bus.funct = F_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        check("mid_rst_hi", 64'(bus.hi), 64'd0);
        check("mid_rst_lo", 64'(bus.lo), 64'd0);
        #1 rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("mid_rst_no_done", 64'(dones), 64'd0);
        @(posedge clk); #2;
        bus.start = 1'b1; bus.funct = F_MTHI; bus.a = 32'h1234;
        @(posedge clk); #2;
        bus.start = 1'b0;
        #1 check("post_rst_mthi", 64'(bus.hi), 64'h1234);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
